// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with occupancy count, threshold flags and sticky error flags.
// FWFT=0 registers rdata on each accepted read; FWFT=1 shows the head entry whenever not empty.
module sync_fifo_flags #(
    parameter int DSIZE    = 8,
    parameter int ASIZE    = 4,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    input  logic             rinc,
    input  logic             clr_err,
    output logic [DSIZE-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow
);
    localparam int DEPTH = 1 << ASIZE;
    localparam logic [ASIZE:0] FULL_CNT = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] AF_CNT = (ASIZE+1)'(AF_LEVEL);
    localparam logic [ASIZE:0] AE_CNT = (ASIZE+1)'(AE_LEVEL);

    logic [DSIZE-1:0] mem_q [DEPTH];
    logic [ASIZE-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [ASIZE:0]   count_q, count_d;
    logic             ovf_q, ovf_d, udf_q, udf_d;
    logic [DSIZE-1:0] rdata_q, rdata_d;
    logic             wr_ok, rd_ok;

    assign count        = count_q;
    assign full         = count_q == FULL_CNT;
    assign empty        = count_q == '0;
    assign almost_full  = count_q >= AF_CNT;
    assign almost_empty = count_q <= AE_CNT;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;
    assign rdata        = (FWFT != 0) ? (empty ? '0 : mem_q[rptr_q]) : rdata_q;

    always_comb begin
        wr_ok   = winc && !full;
        rd_ok   = rinc && !empty;
        wptr_d  = wr_ok ? wptr_q + ASIZE'(1) : wptr_q;
        rptr_d  = rd_ok ? rptr_q + ASIZE'(1) : rptr_q;
        count_d = (wr_ok && !rd_ok) ? count_q + (ASIZE+1)'(1) :
                  (rd_ok && !wr_ok) ? count_q - (ASIZE+1)'(1) : count_q;
        // a new error wins over a coincident clear
        ovf_d   = (winc && full) ? 1'b1 : clr_err ? 1'b0 : ovf_q;
        udf_d   = (rinc && empty) ? 1'b1 : clr_err ? 1'b0 : udf_q;
        rdata_d = (FWFT == 0 && rd_ok) ? mem_q[rptr_q] : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_ok) mem_q[wptr_q] <= wdata;
    end
endmodule
